// File: rtl/mips_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, multiply/divide FSM
// states and the bit positions inside the 5-bit MEM/WB control bundle.
package mips_pkg;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_AND   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_NOR   = 5'd5,
        ALU_SLT   = 5'd6,
        ALU_SLTU  = 5'd7,
        ALU_SLL   = 5'd8,
        ALU_SRL   = 5'd9,
        ALU_SRA   = 5'd10,
        ALU_LUI   = 5'd11,
        ALU_MFHI  = 5'd12,
        ALU_MFLO  = 5'd13,
        ALU_MULT  = 5'd14,
        ALU_MULTU = 5'd15,
        ALU_DIV   = 5'd16,
        ALU_DIVU  = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam int MEM_READ  = 4;
    localparam int MEM_WRITE = 3;
    localparam int WB_MSB    = 2;
    localparam int WB_LSB    = 0;

    function automatic logic is_muldiv(input alu_op_e op);
        return (op == ALU_MULT) || (op == ALU_MULTU) ||
               (op == ALU_DIV)  || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// One bit per cycle on magnitudes; signs are re-applied when entering DONE.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_signed,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MD_CYCLES);

    md_state_e        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_orig;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             is_div, neg_q, neg_r, div_zero;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]        a_mag, b_mag;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_diff;
    logic [WIDTH-1:0]     nxt_hi, nxt_lo;
    logic [2*WIDTH-1:0]   prod, prod_fix;
    logic [WIDTH-1:0]     fin_hi, fin_lo;

    assign a_s   = a;
    assign b_s   = b;
    assign a_mag = (op_signed && a_s < 0) ? -a : a;
    assign b_mag = (op_signed && b_s < 0) ? -b : b;
    assign busy  = (state != MD_IDLE);

    always_comb begin
        add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, opnd});
        rem_diff = rem_sh[WIDTH-1:0] - opnd;
        if (is_div) begin
            nxt_hi = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], rem_ge};
        end else begin
            nxt_hi = add_sum[WIDTH:1];
            nxt_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod     = {nxt_hi, nxt_lo};
        prod_fix = neg_q ? -prod : prod;
        if (!is_div) begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
            fin_hi = a_orig;
            fin_lo = '1;
        end else begin
            fin_hi = neg_r ? -nxt_hi : nxt_hi;
            fin_lo = neg_q ? -nxt_lo : nxt_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        state    <= MD_BUSY;
                        cnt      <= '0;
                        is_div   <= op_div;
                        acc_hi   <= '0;
                        acc_lo   <= op_div ? a_mag : b_mag;
                        opnd     <= op_div ? b_mag : a_mag;
                        a_orig   <= a;
                        neg_q    <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= op_signed & a[WIDTH-1];
                        div_zero <= (b == '0);
                    end
                end
                MD_BUSY: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(MD_CYCLES - 1)) begin
                        state  <= MD_DONE;
                        res_hi <= fin_hi;
                        res_lo <= fin_lo;
                    end
                end
                MD_DONE: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, multiply/divide unit and the EX/MEM pipeline register.
// The mul/div unit stalls ID/EX while busy; issue slots it blocks become bubbles.
module execute_stage
    import mips_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic [4:0]       shamt,
    input  logic [9:0]       RegEx,
    input  logic [4:0]       control_signals_EX,
    output logic [WIDTH-1:0] Mem_Addr,
    output logic [WIDTH-1:0] Mem_Data,
    output logic [9:0]       RegMem,
    output logic [4:0]       control_signals_MEM,
    output logic             stall
);

    alu_op_e                 op_p0;
    logic                    vld_p0, md_issue_p0, load_p0;
    logic [WIDTH-1:0]        opb_p0, alu_p0;
    logic signed [WIDTH-1:0] a_s_p0, b_s_p0;
    logic [WIDTH-1:0]        hi, lo;
    logic                    md_busy;

    assign op_p0       = alu_op_e'(alu_op);
    assign vld_p0      = in_valid & ~flush & ~stall;
    assign md_issue_p0 = vld_p0 & is_muldiv(op_p0);
    assign load_p0     = vld_p0 & ~md_issue_p0;
    assign stall       = md_busy;

    assign opb_p0 = alu_src ? imm : op_b;
    assign a_s_p0 = op_a;
    assign b_s_p0 = opb_p0;

    always_comb begin
        alu_p0 = '0;
        case (op_p0)
            ALU_ADD:  alu_p0 = op_a + opb_p0;
            ALU_SUB:  alu_p0 = op_a - opb_p0;
            ALU_AND:  alu_p0 = op_a & opb_p0;
            ALU_OR:   alu_p0 = op_a | opb_p0;
            ALU_XOR:  alu_p0 = op_a ^ opb_p0;
            ALU_NOR:  alu_p0 = ~(op_a | opb_p0);
            ALU_SLT:  alu_p0 = {{(WIDTH-1){1'b0}}, (a_s_p0 < b_s_p0)};
            ALU_SLTU: alu_p0 = {{(WIDTH-1){1'b0}}, (op_a < opb_p0)};
            ALU_SLL:  alu_p0 = opb_p0 << shamt;
            ALU_SRL:  alu_p0 = opb_p0 >> shamt;
            ALU_SRA:  alu_p0 = b_s_p0 >>> shamt;
            ALU_LUI:  alu_p0 = {imm[15:0], 16'h0000};
            ALU_MFHI: alu_p0 = hi;
            ALU_MFLO: alu_p0 = lo;
            default:  alu_p0 = '0;
        endcase
    end

    muldiv_unit #(
        .WIDTH    (WIDTH),
        .MD_CYCLES(MD_CYCLES)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start    (md_issue_p0),
        .op_signed((op_p0 == ALU_MULT) || (op_p0 == ALU_DIV)),
        .op_div   ((op_p0 == ALU_DIV) || (op_p0 == ALU_DIVU)),
        .a        (op_a),
        .b        (op_b),
        .busy     (md_busy),
        .hi       (hi),
        .lo       (lo)
    );

    // EX/MEM boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            Mem_Addr            <= '0;
            Mem_Data            <= '0;
            RegMem              <= '0;
            control_signals_MEM <= '0;
        end else if (load_p0) begin
            Mem_Addr            <= alu_p0;
            Mem_Data            <= op_b;
            RegMem              <= RegEx;
            control_signals_MEM <= control_signals_EX;
        end else begin
            control_signals_MEM <= '0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, mul/div stall window and HI/LO,
// flush behaviour and reset during a busy multiply.
module tb_execute_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, flush, alu_src;
    logic [4:0]  alu_op, shamt, control_signals_EX, control_signals_MEM;
    logic [31:0] op_a, op_b, imm, Mem_Addr, Mem_Data;
    logic [9:0]  RegEx, RegMem;
    logic        stall;

    int n_checks = 0;
    int n_pass   = 0;

    execute_stage #(.WIDTH(32), .MD_CYCLES(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .flush              (flush),
        .alu_op             (alu_op),
        .op_a               (op_a),
        .op_b               (op_b),
        .imm                (imm),
        .alu_src            (alu_src),
        .shamt              (shamt),
        .RegEx              (RegEx),
        .control_signals_EX (control_signals_EX),
        .Mem_Addr           (Mem_Addr),
        .Mem_Data           (Mem_Data),
        .RegMem             (RegMem),
        .control_signals_MEM(control_signals_MEM),
        .stall              (stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src, input logic [4:0] sh,
                         input logic [4:0] ctl, input logic [9:0] rg);
        in_valid = 1'b1;
        flush = 1'b0;
        alu_op = op;
        op_a = a;
        op_b = b;
        imm = im;
        alu_src = src;
        shamt = sh;
        control_signals_EX = ctl;
        RegEx = rg;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!stall) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(ALU_ADD, 32'h1, 32'h2, 32'h3, 1'b0, 5'd0, 5'h1F, 10'h3FF);
        tick();
        tick();
        n_checks++; if (Mem_Addr !== 32'h0) $display("FAIL reset_addr got=%h want=0", Mem_Addr); else n_pass++;
        n_checks++; if (Mem_Data !== 32'h0) $display("FAIL reset_data got=%h want=0", Mem_Data); else n_pass++;
        n_checks++; if (RegMem !== 10'h0) $display("FAIL reset_reg got=%h want=0", RegMem); else n_pass++;
        n_checks++; if (control_signals_MEM !== 5'h0) $display("FAIL reset_ctl got=%h want=0", control_signals_MEM); else n_pass++;
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b want=0", stall); else n_pass++;
        reset = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_add_wrap();
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'h1, 1'b1, 5'd0, 5'b10101, 10'h155);
        tick();
        n_checks++; if (Mem_Addr !== 32'h8000_0000) $display("FAIL add_addr got=%h want=80000000", Mem_Addr); else n_pass++;
        n_checks++; if (Mem_Data !== 32'hDEAD_BEEF) $display("FAIL add_data got=%h want=deadbeef", Mem_Data); else n_pass++;
        n_checks++; if (RegMem !== 10'h155) $display("FAIL add_reg got=%h want=155", RegMem); else n_pass++;
        n_checks++; if (control_signals_MEM !== 5'b10101) $display("FAIL add_ctl got=%h want=15", control_signals_MEM); else n_pass++;
    endtask

    // Back-to-back ALU issues, one result per cycle.
    task automatic test_alu_ops();
        alu_op_e     ops [12] = '{ALU_SLT, ALU_SLTU, ALU_SUB, ALU_SRA, ALU_SRL, ALU_SLL,
                                  ALU_LUI, ALU_NOR, ALU_XOR, ALU_AND, ALU_OR, ALU_ADD};
        logic [31:0] va  [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h0, 32'h0, 32'h0,
                                  32'h0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h10};
        logic [31:0] vb  [12] = '{32'h1, 32'h1, 32'h7, 32'h8000_0000, 32'h8000_0000, 32'h1,
                                  32'h0, 32'h00FF_00FF, 32'h00FF_00FF, 32'h00FF_00FF, 32'h00FF_00FF, 32'h5};
        logic [31:0] vim [12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h0000_1234, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
        logic        vsr [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0]  vsh [12] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [31:0] exp [12] = '{32'h1, 32'h0, 32'hFFFF_FFFE, 32'hF800_0000, 32'h0800_0000, 32'h8000_0000,
                                  32'h1234_0000, 32'hF000_F000, 32'h0FF0_0FF0, 32'h000F_000F, 32'h0FFF_0FFF, 32'hF};
        for (int i = 0; i < 12; i++) begin
            drive(ops[i], va[i], vb[i], vim[i], vsr[i], vsh[i], 5'b00001, 10'(i));
            tick();
            n_checks++;
            if (Mem_Addr !== exp[i] || control_signals_MEM !== 5'b00001)
                $display("FAIL alu_vec%0d got=%h/%h want=%h/01", i, Mem_Addr, control_signals_MEM, exp[i]);
            else n_pass++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mult_stall();
        bit stall_ok = 1'b1;
        bit ctl_ok   = 1'b1;
        drive(ALU_MULT, 32'hFFFF_FFFD, 32'h7, 32'h0, 1'b0, 5'd0, 5'b00011, 10'h21);
        tick();
        n_checks++; if (stall !== 1'b1 || control_signals_MEM !== 5'h0)
            $display("FAIL mult_issue stall=%b ctl=%h want=1/0", stall, control_signals_MEM); else n_pass++;
        drive(ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'b00010, 10'h3C);
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (stall !== (k <= 32)) begin
                if (stall_ok) $display("FAIL mult_stall_window cycle=%0d stall=%b want=%b", k, stall, (k <= 32));
                stall_ok = 1'b0;
            end
            if (control_signals_MEM !== 5'h0) begin
                if (ctl_ok) $display("FAIL mult_bubble cycle=%0d ctl=%h want=0", k, control_signals_MEM);
                ctl_ok = 1'b0;
            end
        end
        n_checks++; if (stall_ok) n_pass++;
        n_checks++; if (ctl_ok) n_pass++;
        tick();
        n_checks++; if (Mem_Addr !== 32'hFFFF_FFFF || control_signals_MEM !== 5'b00010)
            $display("FAIL mult_mfhi got=%h/%h want=ffffffff/02", Mem_Addr, control_signals_MEM); else n_pass++;
        drive(ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'b00010, 10'h3D);
        tick();
        n_checks++; if (Mem_Addr !== 32'hFFFF_FFEB)
            $display("FAIL mult_mflo got=%h want=ffffffeb", Mem_Addr); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_divide();
        bit ok;
        drive(ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'h0, 1'b0, 5'd0, 5'b00001, 10'h1);
        tick();
        in_valid = 1'b0;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL div_timeout stall=%b want=0", stall); else n_pass++;
        drive(ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'b00001, 10'h2);
        tick();
        n_checks++; if (Mem_Addr !== 32'hFFFF_FFF2) $display("FAIL div_lo got=%h want=fffffff2", Mem_Addr); else n_pass++;
        drive(ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'b00001, 10'h3);
        tick();
        n_checks++; if (Mem_Addr !== 32'h2) $display("FAIL div_hi got=%h want=2", Mem_Addr); else n_pass++;

        drive(ALU_DIVU, 32'd5, 32'd0, 32'h0, 1'b0, 5'd0, 5'b00001, 10'h4);
        tick();
        in_valid = 1'b0;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL divu_timeout stall=%b want=0", stall); else n_pass++;
        drive(ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'b00001, 10'h5);
        tick();
        n_checks++; if (Mem_Addr !== 32'hFFFF_FFFF) $display("FAIL divu0_lo got=%h want=ffffffff", Mem_Addr); else n_pass++;
        drive(ALU_MFHI, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'b00001, 10'h6);
        tick();
        n_checks++; if (Mem_Addr !== 32'h5) $display("FAIL divu0_hi got=%h want=5", Mem_Addr); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        drive(ALU_ADD, 32'h100, 32'hCAFE_0000, 32'h4, 1'b1, 5'd0, 5'b01000, 10'h77);
        flush = 1'b1;
        tick();
        n_checks++; if (control_signals_MEM !== 5'h0 || stall !== 1'b0)
            $display("FAIL flush_store ctl=%h stall=%b want=0/0", control_signals_MEM, stall); else n_pass++;
        drive(ALU_MULT, 32'h3, 32'h3, 32'h0, 1'b0, 5'd0, 5'b00001, 10'h0);
        flush = 1'b1;
        tick();
        n_checks++; if (stall !== 1'b0) $display("FAIL flush_mult stall=%b want=0", stall); else n_pass++;
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        drive(ALU_MULTU, 32'd5, 32'd5, 32'h0, 1'b0, 5'd0, 5'b00001, 10'h0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (stall !== 1'b1) $display("FAIL busy_before_reset stall=%b want=1", stall); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_busy_stall stall=%b want=0", stall); else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 35; i++) tick();
        drive(ALU_MFLO, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'b00100, 10'h9);
        tick();
        n_checks++; if (Mem_Addr !== 32'h0 || control_signals_MEM !== 5'b00100)
            $display("FAIL reset_mflo got=%h/%h want=0/04", Mem_Addr, control_signals_MEM); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        alu_op = '0;
        op_a = '0;
        op_b = '0;
        imm = '0;
        alu_src = 1'b0;
        shamt = '0;
        RegEx = '0;
        control_signals_EX = '0;
        #2;
        test_reset();
        test_add_wrap();
        test_alu_ops();
        test_mult_stall();
        test_divide();
        test_flush();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
